// File: rtl/bsearch_ctrl.sv
// Binary-search controller driving a 4-bit magnitude comparator; converges in at most 5 guesses.
// Optional BSEARCH_SETTLE_EN inserts a settle cycle before each sample (2 cycles per guess instead of 1).
module bsearch_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       lt,
  input  logic       gt,
  input  logic       eq,
  output logic [3:0] guess,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic       err,
  output logic [2:0] steps
);

`ifdef BSEARCH_SETTLE_EN
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_EVAL, S_DONE} state_t;
  localparam state_t S_ISSUE = S_SETTLE;
`else
  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_DONE} state_t;
  localparam state_t S_ISSUE = S_EVAL;
`endif

  state_t     state_q, state_d;
  logic [3:0] lo_q, lo_d, hi_q, hi_d, guess_q, guess_d;
  logic       busy_q, busy_d, done_q, done_d, found_q, found_d, err_q, err_d;
  logic [2:0] steps_q, steps_d;

  logic [3:0] up_lo, dn_hi, mid_up, mid_dn;

  // Floor midpoint taken from a 5-bit sum so lo+hi never wraps.
  function automatic logic [3:0] midpoint(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[4:1];
  endfunction

  assign up_lo  = guess_q + 4'd1;
  assign dn_hi  = guess_q - 4'd1;
  assign mid_up = midpoint(up_lo, hi_q);
  assign mid_dn = midpoint(lo_q, dn_hi);

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    guess_d = guess_q;
    busy_d  = busy_q;
    done_d  = done_q;
    found_d = found_q;
    err_d   = err_q;
    steps_d = steps_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          lo_d    = 4'd0;
          hi_d    = 4'd15;
          guess_d = 4'd7;
          steps_d = 3'd1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_ISSUE;
        end
      end
`ifdef BSEARCH_SETTLE_EN
      S_SETTLE: state_d = S_EVAL;
`endif
      S_EVAL: begin
        // Any exit to DONE leaves guess and steps untouched.
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        case ({lt, gt, eq})
          3'b001: found_d = 1'b1;
          3'b100: begin
            if (guess_q == 4'd15 || up_lo > hi_q) begin
              err_d = 1'b1;
            end else begin
              lo_d    = up_lo;
              guess_d = mid_up;
              steps_d = steps_q + 3'd1;
              busy_d  = 1'b1;
              done_d  = 1'b0;
              state_d = S_ISSUE;
            end
          end
          3'b010: begin
            if (guess_q == 4'd0 || lo_q > dn_hi) begin
              err_d = 1'b1;
            end else begin
              hi_d    = dn_hi;
              guess_d = mid_dn;
              steps_d = steps_q + 3'd1;
              busy_d  = 1'b1;
              done_d  = 1'b0;
              state_d = S_ISSUE;
            end
          end
          default: err_d = 1'b1;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      lo_q    <= 4'd0;
      hi_q    <= 4'd15;
      guess_q <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      found_q <= 1'b0;
      err_q   <= 1'b0;
      steps_q <= 3'd0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      guess_q <= guess_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      found_q <= found_d;
      err_q   <= err_d;
      steps_q <= steps_d;
    end
  end

  assign guess = guess_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign found = found_q;
  assign err   = err_q;
  assign steps = steps_q;

endmodule

// File: tb/tb_bsearch_ctrl.sv
// Scoreboard bench for bsearch_ctrl: plain binary-search model, comparator model with fault modes.
module tb_bsearch_ctrl;

`ifdef BSEARCH_SETTLE_EN
  localparam int PER = 2;
`else
  localparam int PER = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       lt, gt, eq;
  logic [3:0] guess;
  logic       busy, done, found, err;
  logic [2:0] steps;

  int target = 0;
  int mode = 0;      // 0 honest, 1 lt+gt, 2 no flag, 3 scripted lies
  bit hold_mode = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int found;
    int err;
    int steps;
    int guess;
    int n;
    int seq;
  } exp_t;

  exp_t exp_q[$];

  bsearch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lt(lt), .gt(gt), .eq(eq),
    .guess(guess), .busy(busy), .done(done), .found(found), .err(err), .steps(steps)
  );

  always #5 clk = ~clk;

  always_comb begin
    lt = 1'b0;
    gt = 1'b0;
    eq = 1'b0;
    case (mode)
      0: begin
        lt = int'(guess) < target;
        gt = int'(guess) > target;
        eq = int'(guess) == target;
      end
      1: begin
        lt = 1'b1;
        gt = 1'b1;
      end
      2: ;
      default: begin
        lt = (guess == 4'd7) || (guess == 4'd9);
        gt = (guess == 4'd11) || (guess == 4'd10);
        eq = !(lt || gt);
      end
    endcase
  end

  task automatic chk(input string name, input int act, input int expv);
    n_tests++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic exp_t model(input int t);
    exp_t e;
    int lo, hi, g;
    e = '{default: 0};
    lo = 0;
    hi = 15;
    for (int s = 0; s < 8; s++) begin
      g = (lo + hi) / 2;
      e.seq = e.seq | (g << (4 * e.n));
      e.n++;
      e.guess = g;
      if (g == t) begin
        e.found = 1;
        break;
      end
      if (g < t) begin
        if (g == 15) begin e.err = 1; break; end
        lo = g + 1;
      end else begin
        if (g == 0) begin e.err = 1; break; end
        hi = g - 1;
      end
      if (lo > hi) begin e.err = 1; break; end
    end
    e.steps = e.n;
    return e;
  endfunction

  // Monitor: rebuilds the guess sequence and latency, compares on each done rise.
  bit prev_busy = 0, prev_done = 0;
  int busy_cnt = 0, done_len = 0, obs_n = 0, obs_seq = 0, last_g = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 0; prev_done = 0; busy_cnt = 0; done_len = 0; obs_n = 0; obs_seq = 0;
    end else begin
      if (busy && !prev_busy) begin
        if (hold_mode && prev_done) chk("restart_gap", done_len, 1);
        obs_seq = int'(guess);
        obs_n = 1;
        busy_cnt = 1;
        last_g = int'(guess);
      end else if (busy) begin
        busy_cnt++;
        if (int'(guess) != last_g) begin
          obs_seq = obs_seq | (int'(guess) << (4 * obs_n));
          obs_n++;
          last_g = int'(guess);
        end
      end
      if (done && !prev_done) begin
        done_len = 1;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("found", int'(found), e.found);
          chk("err", int'(err), e.err);
          chk("steps", int'(steps), e.steps);
          chk("final_guess", int'(guess), e.guess);
          chk("guess_seq", obs_seq, e.seq);
          chk("guess_count", obs_n, e.n);
          chk("latency", busy_cnt, PER * e.steps);
          chk("busy_in_done", int'(busy), 0);
        end
      end else if (done) begin
        done_len++;
      end
      prev_busy = busy;
      prev_done = done;
    end
  end

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      chk("done_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic run_search(input int t, input int m, input exp_t e);
    target = t;
    mode = m;
    exp_q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("first_guess", int'(guess), 7);
    chk("busy_after_start", int'(busy), 1);
    wait_done();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_guess"}, int'(guess), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_found"}, int'(found), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_steps"}, int'(steps), 0);
  endtask

  initial begin
    exp_t e;
    int k;
    #3;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_search(7, 0, model(7));
    run_search(15, 0, model(15));
    run_search(0, 0, model(0));

    e = '{found: 0, err: 1, steps: 1, guess: 7, n: 1, seq: 7};
    run_search(7, 1, e);
    run_search(7, 2, e);
    e = '{found: 0, err: 1, steps: 4, guess: 10, n: 4, seq: 32'hA9B7};
    run_search(0, 3, e);
    run_search(16, 0, model(16));
    run_search(-1, 0, model(-1));

    // Asynchronous reset in the middle of a search for 13.
    target = 13;
    mode = 0;
    exp_q.push_back(model(13));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (guess != 4'd11 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("reach_guess_11", int'(guess), 11);
    #2 rst_n = 1'b0;
    #1 chk_zero("async_reset");
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_search(13, 0, model(13));

    // Sweep all targets with start held through DONE.
    hold_mode = 1;
    mode = 0;
    target = 0;
    exp_q.push_back(model(0));
    start = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      wait_done();
      if (i < 15) begin
        target = i + 1;
        exp_q.push_back(model(i + 1));
      end else begin
        start = 1'b0;
      end
    end
    @(negedge clk);
    hold_mode = 0;

    for (int i = 0; i < 30; i++) begin
      int t;
      t = int'($urandom_range(0, 17)) - 1;
      run_search(t, 0, model(t));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
